// File: rtl/video_rgb565_packer.sv
// RGB888 -> dual RGB565 AXI4-Stream video packer, two pixels per 32-bit word.
// Optional `VID_PACK_ROUND_EN: round-to-nearest with saturation, one extra stage.
module video_rgb565_packer #(
    parameter int PAD_DUP = 0
) (
    input  logic        vid_aclk,
    input  logic        vid_aresetn,
    input  logic [31:0] m_axis_vid_tdata,
    input  logic        m_axis_vid_tvalid,
    output logic        m_axis_vid_tready,
    input  logic        m_axis_vid_tuser,
    input  logic        m_axis_vid_tlast,
    output logic [31:0] s_axis_vid_tdata,
    output logic        s_axis_vid_tvalid,
    input  logic        s_axis_vid_tready,
    output logic        s_axis_vid_tuser,
    output logic        s_axis_vid_tlast,
    output logic        sof_resync
);

    typedef enum logic {
        ST_LO,
        ST_HI
    } state_e;

    logic rst_meta_q;
    logic rst_sync_q;
    logic rst_n;

    always_ff @(posedge vid_aclk or negedge vid_aresetn) begin
        if (!vid_aresetn) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    assign rst_n = rst_sync_q;

    logic [15:0] cvt565;
    logic        unused_bits;
    logic        out_ready;
    logic        in_fire;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_user;
    logic        pix_last;
    logic        pix_fire;

    assign out_ready = !s_axis_vid_tvalid | s_axis_vid_tready;

`ifdef VID_PACK_ROUND_EN
    logic [8:0] r_sum;
    logic [8:0] g_sum;
    logic [8:0] b_sum;
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;

    always_comb begin
        r_sum = {1'b0, m_axis_vid_tdata[23:16]} + 9'd4;
        g_sum = {1'b0, m_axis_vid_tdata[15:8]} + 9'd2;
        b_sum = {1'b0, m_axis_vid_tdata[7:0]} + 9'd4;
        r5 = r_sum[8] ? 5'h1f : r_sum[7:3];
        g6 = g_sum[8] ? 6'h3f : g_sum[7:2];
        b5 = b_sum[8] ? 5'h1f : b_sum[7:3];
        cvt565 = {b5, g6, r5};
    end

    assign unused_bits = ^{m_axis_vid_tdata[31:24], r_sum[2:0],
                           g_sum[1:0], b_sum[2:0]};

    logic        p_valid_q;
    logic [15:0] p_data_q;
    logic        p_user_q;
    logic        p_last_q;
    logic        p_ready;

    // The rounding stage may refill in the same cycle the packer consumes it.
    assign p_ready           = !p_valid_q | out_ready;
    assign m_axis_vid_tready = rst_n & p_ready;
    assign in_fire           = m_axis_vid_tvalid & m_axis_vid_tready;

    always_ff @(posedge vid_aclk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid_q <= 1'b0;
            p_data_q  <= '0;
            p_user_q  <= 1'b0;
            p_last_q  <= 1'b0;
        end else if (p_ready) begin
            p_valid_q <= in_fire;
            if (in_fire) begin
                p_data_q <= cvt565;
                p_user_q <= m_axis_vid_tuser;
                p_last_q <= m_axis_vid_tlast;
            end
        end
    end

    assign pix_valid = p_valid_q;
    assign pix_data  = p_data_q;
    assign pix_user  = p_user_q;
    assign pix_last  = p_last_q;
`else
    assign cvt565 = {m_axis_vid_tdata[7:3], m_axis_vid_tdata[15:10],
                     m_axis_vid_tdata[23:19]};

    assign unused_bits = ^{m_axis_vid_tdata[31:24], m_axis_vid_tdata[18:16],
                           m_axis_vid_tdata[9:8], m_axis_vid_tdata[2:0]};

    assign m_axis_vid_tready = rst_n & out_ready;
    assign in_fire           = m_axis_vid_tvalid & m_axis_vid_tready;

    assign pix_valid = in_fire;
    assign pix_data  = cvt565;
    assign pix_user  = m_axis_vid_tuser;
    assign pix_last  = m_axis_vid_tlast;
`endif

    assign pix_fire = pix_valid & out_ready;

    state_e      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic        hold_user_q, hold_user_d;
    logic        ov_q, ov_d;
    logic [31:0] od_q, od_d;
    logic        ou_q, ou_d;
    logic        ol_q, ol_d;
    logic        resync_q, resync_d;
    logic [15:0] pad;

    assign pad = (PAD_DUP != 0) ? pix_data : 16'h0000;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_user_d = hold_user_q;
        ov_d        = ov_q & !s_axis_vid_tready;
        od_d        = od_q;
        ou_d        = ou_q;
        ol_d        = ol_q;
        resync_d    = 1'b0;
        if (pix_fire) begin
            if (state_q == ST_HI && !pix_user) begin
                ov_d    = 1'b1;
                od_d    = {pix_data, hold_q};
                ou_d    = hold_user_q;
                ol_d    = pix_last;
                state_d = ST_LO;
            end else begin
                // A SOF arriving mid-pair discards the orphaned low half.
                resync_d = (state_q == ST_HI);
                if (pix_last) begin
                    ov_d    = 1'b1;
                    od_d    = {pad, pix_data};
                    ou_d    = pix_user;
                    ol_d    = 1'b1;
                    state_d = ST_LO;
                end else begin
                    hold_d      = pix_data;
                    hold_user_d = pix_user;
                    state_d     = ST_HI;
                end
            end
        end
    end

    always_ff @(posedge vid_aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LO;
            hold_q      <= '0;
            hold_user_q <= 1'b0;
            ov_q        <= 1'b0;
            od_q        <= '0;
            ou_q        <= 1'b0;
            ol_q        <= 1'b0;
            resync_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_user_q <= hold_user_d;
            ov_q        <= ov_d;
            od_q        <= od_d;
            ou_q        <= ou_d;
            ol_q        <= ol_d;
            resync_q    <= resync_d;
        end
    end

    assign s_axis_vid_tvalid = ov_q;
    assign s_axis_vid_tdata  = od_q;
    assign s_axis_vid_tuser  = ou_q;
    assign s_axis_vid_tlast  = ol_q;
    assign sof_resync        = resync_q;

endmodule
